// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Summary  : Byte FIFO plus handover FSM that feeds a UART transmitter.
// Revision : 1.0
// ============================================================================
module uart_tx_fifo #(
    parameter int DATA_W       = 8,
    parameter int DEPTH        = 16,
    parameter int ADDR_W       = $clog2(DEPTH),
    parameter int BUSY_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_wr_data,
    input  logic              in_wr_en,
    output logic              out_full,
    output logic              out_empty,
    output logic [ADDR_W:0]   out_count,
    output logic              out_ovf,
    input  logic              in_ovf_clear,
    output logic [DATA_W-1:0] out_tx_data,
    output logic              out_tx_valid,
    input  logic              in_tx_busy,
    output logic              out_tx_err,
    input  logic              in_err_clear,
    output logic              out_idle
);

    localparam int                 c_TMR_W    = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(BUSY_TIMEOUT - 1);
    localparam logic [ADDR_W:0]    c_DEPTH    = (ADDR_W+1)'(DEPTH);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WAIT_BUSY = 2'd1;
    localparam logic [1:0] S_WAIT_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [ADDR_W-1:0]  r_wr_ptr;
    logic [ADDR_W-1:0]  r_rd_ptr;
    logic [ADDR_W:0]    r_count;
    logic [c_TMR_W-1:0] r_timer;
    logic [DATA_W-1:0]  r_tx_data;
    logic               r_tx_valid;
    logic               r_ovf;
    logic               r_err;
    logic               w_wr;
    logic               w_drop;
    logic               w_pop;
    logic               w_handover;
    logic               w_timeout;
    logic               w_tick;

    assign out_full     = (r_count == c_DEPTH);
    assign out_empty    = (r_count == '0);
    assign out_idle     = out_empty && (r_state == S_IDLE);
    assign out_count    = r_count;
    assign out_ovf      = r_ovf;
    assign out_tx_err   = r_err;
    assign out_tx_data  = r_tx_data;
    assign out_tx_valid = r_tx_valid;

    // A write against a full FIFO is dropped even if a pop frees a slot this cycle.
    assign w_wr   = in_wr_en && !out_full;
    assign w_drop = in_wr_en && out_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:      if (!out_empty && !in_tx_busy) w_state_nxt = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (in_tx_busy)                  w_state_nxt = S_WAIT_DONE;
                else if (r_timer == c_TMR_LAST) w_state_nxt = S_IDLE;
            end
            S_WAIT_DONE: if (!in_tx_busy) w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_pop      = 1'b0;
        w_handover = 1'b0;
        w_timeout  = 1'b0;
        w_tick     = 1'b0;
        case (r_state)
            S_IDLE:      w_pop = !out_empty && !in_tx_busy;
            S_WAIT_BUSY: begin
                w_handover = in_tx_busy;
                w_timeout  = !in_tx_busy && (r_timer == c_TMR_LAST);
                w_tick     = !in_tx_busy && (r_timer != c_TMR_LAST);
            end
            default: ;
        endcase
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= in_wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_timer    <= '0;
            r_ovf      <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (w_pop) begin
                r_tx_data  <= r_mem[r_rd_ptr];
                r_tx_valid <= 1'b1;
                r_timer    <= '0;
            end else if (w_handover || w_timeout) begin
                r_tx_valid <= 1'b0;
            end else if (w_tick) begin
                r_timer <= r_timer + 1'b1;
            end
            if (w_drop)            r_ovf <= 1'b1;
            else if (in_ovf_clear) r_ovf <= 1'b0;
            if (w_timeout)         r_err <= 1'b1;
            else if (in_err_clear) r_err <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Summary  : Self-checking bench for uart_tx_fifo with a transmitter busy model.
// Revision : 1.0
// ============================================================================
module tb_uart_tx_fifo;

    localparam int DATA_W       = 8;
    localparam int DEPTH        = 16;
    localparam int ADDR_W       = 4;
    localparam int BUSY_TIMEOUT = 64;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DATA_W-1:0] in_wr_data = '0;
    logic              in_wr_en = 1'b0;
    logic              out_full;
    logic              out_empty;
    logic [ADDR_W:0]   out_count;
    logic              out_ovf;
    logic              in_ovf_clear = 1'b0;
    logic [DATA_W-1:0] out_tx_data;
    logic              out_tx_valid;
    logic              in_tx_busy = 1'b0;
    logic              out_tx_err;
    logic              in_err_clear = 1'b0;
    logic              out_idle;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    // Transmitter model: mode 0 = automatic busy pulse, mode 1 = bench drives busy.
    int busy_mode = 1;
    int busy_hold = 3;
    int busy_jit  = 0;
    int busy_dly  = 0;
    int busy_left = 0;

    uart_tx_fifo #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .BUSY_TIMEOUT(BUSY_TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_wr_data(in_wr_data), .in_wr_en(in_wr_en),
        .out_full(out_full), .out_empty(out_empty), .out_count(out_count),
        .out_ovf(out_ovf), .in_ovf_clear(in_ovf_clear),
        .out_tx_data(out_tx_data), .out_tx_valid(out_tx_valid),
        .in_tx_busy(in_tx_busy),
        .out_tx_err(out_tx_err), .in_err_clear(in_err_clear),
        .out_idle(out_idle)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1);
    end

    // Busy generator and handover monitor; a byte is taken when valid and busy meet.
    initial forever begin
        @(negedge clk);
        if (busy_mode == 1) begin
            busy_dly = 0;
        end else if (in_tx_busy) begin
            busy_left--;
            if (busy_left <= 0) in_tx_busy = 1'b0;
        end else if (out_tx_valid) begin
            busy_dly++;
            if (busy_dly >= 2) begin
                in_tx_busy = 1'b1;
                busy_left  = busy_hold + $urandom_range(0, busy_jit);
                busy_dly   = 0;
            end
        end else begin
            busy_dly = 0;
        end
        if (rst_n && out_tx_valid && in_tx_busy) got_q.push_back(out_tx_data);
    end

    task automatic wait_idle(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (out_idle) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        busy_mode = 1;
        repeat (3) @(negedge clk);
        n_checks++; if (out_tx_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", out_tx_valid); else n_pass++;
        n_checks++; if (out_tx_data !== 8'h00) $display("FAIL reset_data: got %h expected 00", out_tx_data); else n_pass++;
        n_checks++; if (out_empty !== 1'b1 || out_full !== 1'b0) $display("FAIL reset_empty_full: got %b%b expected 10", out_empty, out_full); else n_pass++;
        n_checks++; if (out_count !== 5'd0) $display("FAIL reset_count: got %0d expected 0", out_count); else n_pass++;
        n_checks++; if (out_ovf !== 1'b0 || out_tx_err !== 1'b0) $display("FAIL reset_flags: got %b%b expected 00", out_ovf, out_tx_err); else n_pass++;
        n_checks++; if (out_idle !== 1'b1) $display("FAIL reset_idle: got %b expected 1", out_idle); else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_byte;
        bit ok;
        got_q.delete();
        busy_hold = 100; busy_jit = 0; busy_mode = 0;
        in_wr_data = 8'h36; in_wr_en = 1'b1;
        @(negedge clk);
        in_wr_en = 1'b0;
        n_checks++; if (out_count !== 5'd1 || out_tx_valid !== 1'b0) $display("FAIL single_after_write: got count %0d valid %b expected 1 0", out_count, out_tx_valid); else n_pass++;
        @(negedge clk);
        n_checks++; if (out_tx_valid !== 1'b1 || out_tx_data !== 8'h36) $display("FAIL single_present: got valid %b data %h expected 1 36", out_tx_valid, out_tx_data); else n_pass++;
        n_checks++; if (out_count !== 5'd0) $display("FAIL single_count_pop: got %0d expected 0", out_count); else n_pass++;
        @(negedge clk);
        n_checks++; if (out_tx_valid !== 1'b1) $display("FAIL single_hold: got %b expected 1", out_tx_valid); else n_pass++;
        @(negedge clk);
        n_checks++; if (out_tx_valid !== 1'b0 || out_idle !== 1'b0) $display("FAIL single_handover: got valid %b idle %b expected 0 0", out_tx_valid, out_idle); else n_pass++;
        wait_idle(300, ok);
        n_checks++; if (ok !== 1'b1 || in_tx_busy !== 1'b0) $display("FAIL single_idle: got idle %b busy %b expected 1 0", ok, in_tx_busy); else n_pass++;
        n_checks++; if (got_q.size() != 1 || got_q[0] !== 8'h36) $display("FAIL single_sent: got %0d bytes first %h expected 1 byte 36", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx); else n_pass++;
    endtask

    task automatic test_overflow;
        bit ok;
        int mcount = 0;
        exp_q.delete(); got_q.delete();
        busy_mode = 1; in_tx_busy = 1'b1;
        for (int i = 0; i < 17; i++) begin
            in_wr_data = 8'(i); in_wr_en = 1'b1;
            if (mcount < DEPTH) begin
                exp_q.push_back(8'(i));
                mcount++;
            end
            @(negedge clk);
            if (i == DEPTH - 1) begin
                n_checks++; if (out_full !== 1'b1 || out_ovf !== 1'b0) $display("FAIL ovf_at_full: got full %b ovf %b expected 1 0", out_full, out_ovf); else n_pass++;
            end
        end
        in_wr_en = 1'b0;
        n_checks++; if (out_count !== 5'(mcount) || out_full !== 1'b1) $display("FAIL ovf_count: got %0d full %b expected %0d 1", out_count, out_full, mcount); else n_pass++;
        n_checks++; if (out_ovf !== 1'b1) $display("FAIL ovf_flag: got %b expected 1", out_ovf); else n_pass++;
        busy_hold = 3; busy_jit = 2; busy_dly = 0;
        in_tx_busy = 1'b0; busy_mode = 0;
        wait_idle(800, ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL ovf_drain_timeout: got idle %b expected 1", ok); else n_pass++;
        n_checks++; if (got_q.size() != exp_q.size()) $display("FAIL ovf_drain_len: got %0d expected %0d", got_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) $display("FAIL ovf_drain_byte%0d: got %h expected %h", i, got_q[i], exp_q[i]); else n_pass++;
        end
        n_checks++; if (out_ovf !== 1'b1) $display("FAIL ovf_sticky: got %b expected 1", out_ovf); else n_pass++;
        in_ovf_clear = 1'b1;
        @(negedge clk);
        in_ovf_clear = 1'b0;
        n_checks++; if (out_ovf !== 1'b0) $display("FAIL ovf_clear: got %b expected 0", out_ovf); else n_pass++;
    endtask

    task automatic test_concurrent;
        bit ok;
        logic [7:0] b;
        exp_q.delete(); got_q.delete();
        busy_mode = 1; in_tx_busy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            b = 8'($urandom);
            in_wr_data = b; in_wr_en = 1'b1; exp_q.push_back(b);
            @(negedge clk);
        end
        in_wr_en = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (out_tx_valid !== 1'b0 || out_count !== 5'd3) $display("FAIL busy_blocks_pop: got valid %b count %0d expected 0 3", out_tx_valid, out_count); else n_pass++;
        b = 8'($urandom);
        in_tx_busy = 1'b0; in_wr_data = b; in_wr_en = 1'b1; exp_q.push_back(b);
        @(negedge clk);
        in_wr_en = 1'b0;
        n_checks++; if (out_count !== 5'd3) $display("FAIL wr_pop_count: got %0d expected 3", out_count); else n_pass++;
        n_checks++; if (out_tx_valid !== 1'b1 || out_tx_data !== exp_q[0]) $display("FAIL wr_pop_head: got valid %b data %h expected 1 %h", out_tx_valid, out_tx_data, exp_q[0]); else n_pass++;
        busy_hold = 2; busy_jit = 2; busy_mode = 0;
        wait_idle(400, ok);
        n_checks++; if (ok !== 1'b1 || got_q.size() != exp_q.size()) $display("FAIL conc_len: got idle %b bytes %0d expected 1 %0d", ok, got_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) $display("FAIL conc_byte%0d: got %h expected %h", i, got_q[i], exp_q[i]); else n_pass++;
        end
    endtask

    // Streams bytes with random gaps while the FSM drains; pointers wrap many times.
    task automatic stream(input string name, input int nbytes, input bit alt, input int gap_pct);
        bit ok;
        int sent = 0;
        int cyc  = 0;
        int maxc = 0;
        logic [7:0] b;
        exp_q.delete(); got_q.delete();
        busy_mode = 0;
        while (sent < nbytes && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (int'(out_count) > maxc) maxc = int'(out_count);
            if ((sent - got_q.size()) < 14 && $urandom_range(0, 99) >= gap_pct) begin
                b = alt ? ((sent % 2) ? 8'h78 : 8'h36) : 8'($urandom);
                in_wr_data = b; in_wr_en = 1'b1; exp_q.push_back(b);
                sent++;
            end else begin
                in_wr_en = 1'b0;
            end
        end
        @(negedge clk);
        in_wr_en = 1'b0;
        wait_idle(2000, ok);
        n_checks++; if (ok !== 1'b1 || got_q.size() != exp_q.size()) $display("FAIL %s_len: got idle %b bytes %0d expected 1 %0d", name, ok, got_q.size(), exp_q.size()); else n_pass++;
        n_checks++; if (maxc > DEPTH || out_ovf !== 1'b0) $display("FAIL %s_count_bound: got max %0d ovf %b expected <=%0d 0", name, maxc, out_ovf, DEPTH); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) $display("FAIL %s_byte%0d: got %h expected %h", name, i, got_q[i], exp_q[i]); else n_pass++;
        end
    endtask

    task automatic test_wrap;
        busy_hold = 2; busy_jit = 3;
        stream("wrap", 40, 1'b1, 40);
    endtask

    task automatic test_back_to_back;
        busy_hold = 1; busy_jit = 0;
        stream("b2b", 24, 1'b0, 0);
    endtask

    task automatic test_timeout;
        int hi = 0;
        busy_mode = 1; in_tx_busy = 1'b0; got_q.delete();
        in_wr_data = 8'hA5; in_wr_en = 1'b1;
        @(negedge clk);
        in_wr_en = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (out_tx_valid) hi++;
            else if (hi > 0) break;
        end
        n_checks++; if (hi != BUSY_TIMEOUT) $display("FAIL timeout_len: got %0d cycles expected %0d", hi, BUSY_TIMEOUT); else n_pass++;
        n_checks++; if (out_tx_err !== 1'b1 || out_empty !== 1'b1 || out_idle !== 1'b1) $display("FAIL timeout_state: got err %b empty %b idle %b expected 1 1 1", out_tx_err, out_empty, out_idle); else n_pass++;
        n_checks++; if (got_q.size() != 0) $display("FAIL timeout_no_send: got %0d bytes expected 0", got_q.size()); else n_pass++;
        in_err_clear = 1'b1;
        @(negedge clk);
        in_err_clear = 1'b0;
        n_checks++; if (out_tx_err !== 1'b0) $display("FAIL err_clear: got %b expected 0", out_tx_err); else n_pass++;
        // Second timeout with clear held through the timeout edge.
        hi = 0;
        in_wr_data = 8'hA5; in_wr_en = 1'b1;
        @(negedge clk);
        in_wr_en = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (out_tx_valid) begin
                hi++;
                in_err_clear = 1'b1;
            end else if (hi > 0) begin
                in_err_clear = 1'b0;
                break;
            end
        end
        in_err_clear = 1'b0;
        @(negedge clk);
        n_checks++; if (out_tx_err !== 1'b1 || hi != BUSY_TIMEOUT) $display("FAIL err_set_wins: got err %b len %0d expected 1 %0d", out_tx_err, hi, BUSY_TIMEOUT); else n_pass++;
    endtask

    task automatic test_reset_mid;
        bit ok;
        bit seen = 1'b0;
        busy_mode = 1; in_tx_busy = 1'b0;
        for (int k = 0; k < 6; k++) begin
            in_wr_data = 8'($urandom); in_wr_en = 1'b1;
            @(negedge clk);
        end
        in_wr_en = 1'b0;
        n_checks++; if (out_tx_valid !== 1'b1 || out_count !== 5'd5) $display("FAIL rst_setup: got valid %b count %0d expected 1 5", out_tx_valid, out_count); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (out_tx_valid !== 1'b0 || out_tx_data !== 8'h00) $display("FAIL rst_async_tx: got valid %b data %h expected 0 00", out_tx_valid, out_tx_data); else n_pass++;
        n_checks++; if (out_count !== 5'd0 || out_empty !== 1'b1 || out_idle !== 1'b1) $display("FAIL rst_async_fifo: got count %0d empty %b idle %b expected 0 1 1", out_count, out_empty, out_idle); else n_pass++;
        n_checks++; if (out_tx_err !== 1'b0 || out_ovf !== 1'b0) $display("FAIL rst_async_flags: got err %b ovf %b expected 0 0", out_tx_err, out_ovf); else n_pass++;
        @(negedge clk);
        #2 rst_n = 1'b1;
        got_q.delete(); exp_q.delete();
        busy_hold = 2; busy_jit = 0; busy_mode = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_tx_valid || out_count != 0) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0 || got_q.size() != 0) $display("FAIL rst_no_emit: got activity %b bytes %0d expected 0 0", seen, got_q.size()); else n_pass++;
        in_wr_data = 8'h5A; in_wr_en = 1'b1; exp_q.push_back(8'h5A);
        @(negedge clk);
        in_wr_en = 1'b0;
        wait_idle(200, ok);
        n_checks++; if (ok !== 1'b1 || got_q.size() != 1 || got_q[0] !== exp_q[0]) $display("FAIL rst_resume: got idle %b bytes %0d expected 1 1 byte 5a", ok, got_q.size()); else n_pass++;
    endtask

    initial begin
        test_reset;
        test_single_byte;
        test_overflow;
        test_concurrent;
        test_wrap;
        test_back_to_back;
        test_timeout;
        test_reset_mid;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
